// File: rtl/matmul_pkg.sv
// matmul_pkg: types and helpers shared by the matrix-multiply read scheduler
// and the load-side memory write controller.
//   sched_state_t : read scheduler FSM states (IDLE, RUN, DRAIN, DONE)
//   addr_width(n) : operand memory address width for an n x n matrix
//   idx_width(n)  : row/column/inner index width for an n x n matrix
package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  function automatic int addr_width(input int n);
    return $clog2(n * n);
  endfunction

  function automatic int idx_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/matmul_index_counter.sv
// matmul_index_counter: nested inner (k), column (j) and row (i) counter.
// k advances fastest; j advances when k wraps; i advances when j wraps.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   clr                 load all indices with 0 (has priority over en)
//   en                  advance by one step
//   i_idx, j_idx, k_idx current indices
//   i_last/j_last/k_last index currently equals N-1
module matmul_index_counter
  import matmul_pkg::*;
#(
  parameter int N  = 8,
  parameter int IW = idx_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [IW-1:0] i_idx,
  output logic [IW-1:0] j_idx,
  output logic [IW-1:0] k_idx,
  output logic          i_last,
  output logic          j_last,
  output logic          k_last
);

  logic [IW-1:0] i_q, i_d;
  logic [IW-1:0] j_q, j_d;
  logic [IW-1:0] k_q, k_d;

  assign i_last = (i_q == IW'(N - 1));
  assign j_last = (j_q == IW'(N - 1));
  assign k_last = (k_q == IW'(N - 1));

  always_comb begin
    i_d = i_q;
    j_d = j_q;
    k_d = k_q;
    if (clr) begin
      i_d = '0;
      j_d = '0;
      k_d = '0;
    end else if (en) begin
      // N is a power of two, so natural wrap of the +1 gives the N-1 -> 0 step.
      k_d = k_q + 1'b1;
      if (k_last) begin
        j_d = j_q + 1'b1;
        if (j_last) begin
          i_d = i_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
      k_q <= k_d;
    end
  end

  assign i_idx = i_q;
  assign j_idx = j_q;
  assign k_idx = k_q;

endmodule

// File: rtl/matmul_read_scheduler.sv
// matmul_read_scheduler: issues one paired A/B operand read per cycle while
// walking C = A x B in (i, j, k) order, with MAC control delayed one cycle to
// line up with the 1-cycle memory read latency.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   start                       begin one multiplication (sampled in IDLE only)
//   hold                        result-path stall; suppresses new reads in RUN
//   rd_address_a/rd_address_b   operand memory read addresses
//   rd_en                       read strobe to both memories
//   mac_valid/first/last        MAC control for the data now on the memory outputs
//   mac_row/mac_col             C element the current term belongs to
//   busy                        high in RUN and DRAIN
//   done                        one-cycle completion pulse
// Build option: define MATMUL_SCHED_B_COLMAJOR_EN when B is stored
// column-major; B addresses become j*N + k instead of k*N + j.
module matmul_read_scheduler
  import matmul_pkg::*;
#(
  parameter int N  = 8,
  parameter int AW = addr_width(N),
  parameter int IW = idx_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          hold,
  output logic [AW-1:0] rd_address_a,
  output logic [AW-1:0] rd_address_b,
  output logic          rd_en,
  output logic          mac_valid,
  output logic          mac_first,
  output logic          mac_last,
  output logic [IW-1:0] mac_row,
  output logic [IW-1:0] mac_col,
  output logic          busy,
  output logic          done
);

  sched_state_t  state_q, state_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          mac_valid_q, mac_valid_d;
  logic          mac_first_q, mac_first_d;
  logic          mac_last_q, mac_last_d;
  logic [IW-1:0] mac_row_q, mac_row_d;
  logic [IW-1:0] mac_col_q, mac_col_d;

  logic [IW-1:0] i_idx, j_idx, k_idx;
  logic          i_last, j_last, k_last;
  logic          issue;

  // A read goes out every RUN cycle that the result path is not stalling.
  assign issue = (state_q == RUN) && !hold;

  // Counters sit at zero outside RUN; they also wrap back to zero on the last read.
  matmul_index_counter #(.N(N), .IW(IW)) u_idx (
    .clk   (clk),
    .rst   (rst),
    .clr   (state_q != RUN),
    .en    (issue),
    .i_idx (i_idx),
    .j_idx (j_idx),
    .k_idx (k_idx),
    .i_last(i_last),
    .j_last(j_last),
    .k_last(k_last)
  );

  // Products of N-range indices with N fit in AW bits since N is a power of two.
  assign rd_address_a = AW'(i_idx) * AW'(N) + AW'(k_idx);
`ifdef MATMUL_SCHED_B_COLMAJOR_EN
  assign rd_address_b = AW'(j_idx) * AW'(N) + AW'(k_idx);
`else
  assign rd_address_b = AW'(k_idx) * AW'(N) + AW'(j_idx);
`endif
  assign rd_en = issue;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (issue && i_last && j_last && k_last) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == DONE);

    // Issue-cycle control captured for the cycle the read data arrives.
    mac_valid_d = issue;
    mac_first_d = issue && (k_idx == '0);
    mac_last_d  = issue && k_last;
    mac_row_d   = issue ? i_idx : '0;
    mac_col_d   = issue ? j_idx : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mac_valid_q <= 1'b0;
      mac_first_q <= 1'b0;
      mac_last_q  <= 1'b0;
      mac_row_q   <= '0;
      mac_col_q   <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mac_valid_q <= mac_valid_d;
      mac_first_q <= mac_first_d;
      mac_last_q  <= mac_last_d;
      mac_row_q   <= mac_row_d;
      mac_col_q   <= mac_col_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mac_valid = mac_valid_q;
  assign mac_first = mac_first_q;
  assign mac_last  = mac_last_q;
  assign mac_row   = mac_row_q;
  assign mac_col   = mac_col_q;

endmodule

// File: tb/tb_matmul_read_scheduler.sv
// Bench for matmul_read_scheduler: an N=2 instance and an N=4 instance.
module tb_matmul_read_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // N = 2 instance
  logic       rst2, start2, hold2;
  logic [1:0] a2, b2;
  logic       rd_en2, mv2, mf2, ml2, busy2, done2;
  logic [0:0] row2, col2;

  matmul_read_scheduler #(.N(2), .AW(2), .IW(1)) u_n2 (
    .clk(clk), .rst(rst2), .start(start2), .hold(hold2),
    .rd_address_a(a2), .rd_address_b(b2), .rd_en(rd_en2),
    .mac_valid(mv2), .mac_first(mf2), .mac_last(ml2),
    .mac_row(row2), .mac_col(col2), .busy(busy2), .done(done2)
  );

  // N = 4 instance
  logic       rst4, start4, hold4;
  logic [3:0] a4, b4;
  logic       rd_en4, mv4, mf4, ml4, busy4, done4;
  logic [1:0] row4, col4;

  matmul_read_scheduler #(.N(4), .AW(4), .IW(2)) u_n4 (
    .clk(clk), .rst(rst4), .start(start4), .hold(hold4),
    .rd_address_a(a4), .rd_address_b(b4), .rd_en(rd_en4),
    .mac_valid(mv4), .mac_first(mf4), .mac_last(ml4),
    .mac_row(row4), .mac_col(col4), .busy(busy4), .done(done4)
  );

  typedef struct {
    int a;
    int b;
    int first;
    int last;
    int row;
    int col;
  } vec_t;

  vec_t tab[8];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // One cycle on the N=2 instance: inputs change just after the edge,
  // outputs are sampled on the falling edge.
  task automatic cyc2(input logic st, input logic hd, input logic rs);
    @(posedge clk);
    #1;
    start2 = st;
    hold2  = hd;
    rst2   = rs;
    @(negedge clk);
  endtask

  task automatic cyc4(input logic st, input logic hd);
    @(posedge clk);
    #1;
    start4 = st;
    hold4  = hd;
    @(negedge clk);
  endtask

  // Start pulse in cycle 0, then checks for every cycle up to done + 1.
  task automatic run_n2_nominal(input string tag);
    cyc2(1'b1, 1'b0, 1'b0);
    for (int t = 1; t <= 8; t++) begin
      cyc2(1'b0, 1'b0, 1'b0);
      $display("%s cycle %0d: rd_en=%0d a=%0d b=%0d mac_valid=%0d", tag, t, rd_en2, a2, b2, mv2);
      check({tag, " rd_en"}, int'(rd_en2), 1);
      check({tag, " addr_a"}, int'(a2), tab[t-1].a);
      check({tag, " addr_b"}, int'(b2), tab[t-1].b);
      check({tag, " busy"}, int'(busy2), 1);
      if (t >= 2) begin
        check({tag, " mac_valid"}, int'(mv2), 1);
        check({tag, " mac_first"}, int'(mf2), tab[t-2].first);
        check({tag, " mac_last"}, int'(ml2), tab[t-2].last);
        check({tag, " mac_row"}, int'(row2), tab[t-2].row);
        check({tag, " mac_col"}, int'(col2), tab[t-2].col);
      end else begin
        check({tag, " mac_valid_c1"}, int'(mv2), 0);
      end
    end
    cyc2(1'b0, 1'b0, 1'b0);  // cycle 9: DRAIN, last MAC term
    $display("%s cycle 9: rd_en=%0d mac_valid=%0d busy=%0d done=%0d", tag, rd_en2, mv2, busy2, done2);
    check({tag, " drain rd_en"}, int'(rd_en2), 0);
    check({tag, " drain mac_valid"}, int'(mv2), 1);
    check({tag, " drain mac_last"}, int'(ml2), tab[7].last);
    check({tag, " drain mac_row"}, int'(row2), tab[7].row);
    check({tag, " drain busy"}, int'(busy2), 1);
    check({tag, " drain done"}, int'(done2), 0);
    cyc2(1'b0, 1'b0, 1'b0);  // cycle 10: DONE
    $display("%s cycle 10: busy=%0d done=%0d mac_valid=%0d", tag, busy2, done2, mv2);
    check({tag, " done c10"}, int'(done2), 1);
    check({tag, " busy c10"}, int'(busy2), 0);
    check({tag, " mac_valid c10"}, int'(mv2), 0);
    cyc2(1'b0, 1'b0, 1'b0);  // cycle 11: IDLE
    check({tag, " done c11"}, int'(done2), 0);
  endtask

  initial begin
    int done_cyc[3];
    int nd;
    int r;
    int d4;
    int hb;

    // Expected N=2 read/MAC sequence: k fastest, then j, then i.
    tab[0] = '{a: 0, b: 0, first: 1, last: 0, row: 0, col: 0};
    tab[1] = '{a: 1, b: 2, first: 0, last: 1, row: 0, col: 0};
    tab[2] = '{a: 0, b: 1, first: 1, last: 0, row: 0, col: 1};
    tab[3] = '{a: 1, b: 3, first: 0, last: 1, row: 0, col: 1};
    tab[4] = '{a: 2, b: 0, first: 1, last: 0, row: 1, col: 0};
    tab[5] = '{a: 3, b: 2, first: 0, last: 1, row: 1, col: 0};
    tab[6] = '{a: 2, b: 1, first: 1, last: 0, row: 1, col: 1};
    tab[7] = '{a: 3, b: 3, first: 0, last: 1, row: 1, col: 1};
`ifdef MATMUL_SCHED_B_COLMAJOR_EN
    tab[1].b = 1; tab[2].b = 2; tab[5].b = 1; tab[6].b = 2;
`endif

    rst2 = 1'b1; start2 = 1'b0; hold2 = 1'b0;
    rst4 = 1'b1; start4 = 1'b0; hold4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst2 = 1'b0;
    rst4 = 1'b0;
    @(negedge clk);

    // Reset state
    $display("reset: rd_en=%0d a=%0d b=%0d mac_valid=%0d busy=%0d done=%0d", rd_en2, a2, b2, mv2, busy2, done2);
    check("reset rd_en", int'(rd_en2), 0);
    check("reset addr_a", int'(a2), 0);
    check("reset addr_b", int'(b2), 0);
    check("reset mac_valid", int'(mv2), 0);
    check("reset busy", int'(busy2), 0);
    check("reset done", int'(done2), 0);

    // Nominal N=2 run
    run_n2_nominal("n2");

    // Reset in cycle 4 of a run
    cyc2(1'b1, 1'b0, 1'b0);
    for (int t = 1; t <= 3; t++) cyc2(1'b0, 1'b0, 1'b0);
    cyc2(1'b0, 1'b0, 1'b1);  // cycle 4: rst high
    cyc2(1'b0, 1'b0, 1'b0);  // cycle 5
    $display("after rst: rd_en=%0d a=%0d b=%0d mv=%0d busy=%0d done=%0d", rd_en2, a2, b2, mv2, busy2, done2);
    check("rst rd_en", int'(rd_en2), 0);
    check("rst addr_a", int'(a2), 0);
    check("rst addr_b", int'(b2), 0);
    check("rst mac_valid", int'(mv2), 0);
    check("rst mac_first", int'(mf2), 0);
    check("rst mac_last", int'(ml2), 0);
    check("rst mac_row", int'(row2), 0);
    check("rst mac_col", int'(col2), 0);
    check("rst busy", int'(busy2), 0);
    check("rst done", int'(done2), 0);
    run_n2_nominal("n2 after rst");

    // start held high: done every N^3+3 = 11 cycles
    nd = 0;
    done_cyc[0] = -1; done_cyc[1] = -1; done_cyc[2] = -1;
    for (int t = 0; t < 40; t++) begin
      cyc2(1'b1, 1'b0, 1'b0);
      if (done2) begin
        $display("continuous start: done in cycle %0d", t);
        if (nd < 3) done_cyc[nd] = t;
        nd++;
      end
    end
    cyc2(1'b0, 1'b0, 1'b0);
    check("cont done #1 cycle", done_cyc[0], 10);
    check("cont done #2 cycle", done_cyc[1], 21);
    check("cont done #3 cycle", done_cyc[2], 32);

    // N=4 with hold in cycles 5..7 (the cycles read 5 would have issued)
    r = 0;
    d4 = -1;
    hb = 1;  // read 5 = (i0, j1, k0): B row-major k*4+j
`ifdef MATMUL_SCHED_B_COLMAJOR_EN
    hb = 4;
`endif
    cyc4(1'b1, 1'b0);
    for (int t = 1; t <= 200; t++) begin
      cyc4(1'b0, (t >= 5 && t <= 7));
      if (t >= 5 && t <= 8) begin
        $display("n4 cycle %0d: hold=%0d rd_en=%0d a=%0d b=%0d mac_valid=%0d", t, hold4, rd_en4, a4, b4, mv4);
        check("n4 held addr_a", int'(a4), 0);
        check("n4 held addr_b", int'(b4), hb);
        check("n4 hold rd_en", int'(rd_en4), (t == 8) ? 1 : 0);
        check("n4 hold mac_valid", int'(mv4), (t == 5) ? 1 : 0);
      end
      if (rd_en4) begin
        check("n4 addr_a", int'(a4), (r / 16) * 4 + (r % 4));
`ifdef MATMUL_SCHED_B_COLMAJOR_EN
        check("n4 addr_b", int'(b4), ((r / 4) % 4) * 4 + (r % 4));
`else
        check("n4 addr_b", int'(b4), (r % 4) * 4 + ((r / 4) % 4));
`endif
        r++;
      end
      if (done4) begin
        d4 = t;
        break;
      end
    end
    $display("n4: %0d reads, done in cycle %0d", r, d4);
    check("n4 read count", r, 64);
    check("n4 done cycle", d4, 69);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
